user_obi_demux: RTL and testbench

- Parametrised OBI subordinate demultiplexer for the user domain, between the main crossbar's user port and N user subordinates.
- Decodes each request against a per-subordinate base/size table and forwards it to the matching subordinate.
- Returns responses to the manager in request order, tracking up to MaxTrans outstanding transactions.
- Unmatched addresses go to a built-in error subordinate that always answers with err=1.

---
 rtl/user_obi_demux.sv | 164 ++++++++++++++++
 tb/tb_user_obi_demux.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_demux.sv
// OBI demultiplexer for the user domain: address-decodes each request onto one of NumSbr
// subordinates (or a built-in error subordinate) and returns responses in request order.
module user_obi_demux #(
    parameter int unsigned                     NumSbr    = 2,
    parameter int unsigned                     AddrWidth = 32,
    parameter int unsigned                     DataWidth = 32,
    parameter int unsigned                     IdWidth   = 1,
    parameter int unsigned                     MaxTrans  = 4,
    parameter logic [NumSbr*AddrWidth-1:0]     SbrBase   = {32'h2000_1000, 32'h2000_0000},
    parameter logic [NumSbr*AddrWidth-1:0]     SbrSize   = {32'h0000_1000, 32'h0000_1000},
    parameter logic [DataWidth-1:0]            ErrRdata  = 32'hBADC_AB1E
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          mgr_req_i,
    output logic                          mgr_gnt_o,
    input  logic [AddrWidth-1:0]          mgr_addr_i,
    input  logic                          mgr_we_i,
    input  logic [DataWidth/8-1:0]        mgr_be_i,
    input  logic [DataWidth-1:0]          mgr_wdata_i,
    input  logic [IdWidth-1:0]            mgr_aid_i,
    output logic                          mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic                          mgr_err_o,
    output logic [IdWidth-1:0]            mgr_rid_o,
    output logic [NumSbr-1:0]             sbr_req_o,
    input  logic [NumSbr-1:0]             sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    output logic [IdWidth-1:0]            sbr_aid_o,
    input  logic [NumSbr-1:0]             sbr_rvalid_i,
    input  logic [NumSbr*DataWidth-1:0]   sbr_rdata_i,
    input  logic [NumSbr-1:0]             sbr_err_i,
    input  logic [NumSbr*IdWidth-1:0]     sbr_rid_i,
    output logic                          unexp_rsp_o
);

    localparam int unsigned SelW = $clog2(NumSbr + 1);
    localparam int unsigned PtrW = $clog2(MaxTrans);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [SelW-1:0] ErrSel = SelW'(NumSbr);

    logic [SelW-1:0]    sel;
    logic               full, empty, push, pop, unexp_hit;
    logic [SelW-1:0]    head_tgt;
    logic [SelW-1:0]    tgt_q [MaxTrans];
    logic [IdWidth-1:0] id_q  [MaxTrans];
    logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               unexp_q, unexp_d;

    // Limit is computed one bit wider so a region ending at the top of memory does not wrap.
    always_comb begin
        logic                 found;
        logic [AddrWidth-1:0] base;
        logic [AddrWidth:0]   limit;
        sel   = ErrSel;
        found = 1'b0;
        for (int i = 0; i < NumSbr; i++) begin
            base  = SbrBase[i*AddrWidth +: AddrWidth];
            limit = {1'b0, base} + {1'b0, SbrSize[i*AddrWidth +: AddrWidth]};
            if (!found && (mgr_addr_i >= base) && ({1'b0, mgr_addr_i} < limit)) begin
                sel   = SelW'(i);
                found = 1'b1;
            end
        end
    end

    assign full  = (cnt_q == CntW'(MaxTrans));
    assign empty = (cnt_q == '0);

    always_comb begin
        sbr_req_o = '0;
        mgr_gnt_o = ~full & (sel == ErrSel);
        for (int i = 0; i < NumSbr; i++) begin
            if (sel == SelW'(i)) begin
                sbr_req_o[i] = mgr_req_i & ~full;
                mgr_gnt_o    = ~full & sbr_gnt_i[i];
            end
        end
    end

    assign push        = mgr_req_i & mgr_gnt_o;
    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    assign head_tgt = tgt_q[rptr_q];

    always_comb begin
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = '0;
        mgr_err_o    = 1'b0;
        mgr_rid_o    = '0;
        pop          = 1'b0;
        unexp_hit    = 1'b0;
        if (!empty) begin
            if (head_tgt == ErrSel) begin
                mgr_rvalid_o = 1'b1;
                mgr_rdata_o  = ErrRdata;
                mgr_err_o    = 1'b1;
                mgr_rid_o    = id_q[rptr_q];
                pop          = 1'b1;
            end else begin
                for (int i = 0; i < NumSbr; i++) begin
                    if (head_tgt == SelW'(i)) begin
                        mgr_rvalid_o = sbr_rvalid_i[i];
                        mgr_rdata_o  = sbr_rdata_i[i*DataWidth +: DataWidth];
                        mgr_err_o    = sbr_err_i[i];
                        mgr_rid_o    = sbr_rid_i[i*IdWidth +: IdWidth];
                        pop          = sbr_rvalid_i[i];
                    end
                end
            end
        end
        // Any subordinate answering while it is not the head is out of protocol.
        for (int j = 0; j < NumSbr; j++) begin
            if (sbr_rvalid_i[j] && (empty || head_tgt != SelW'(j))) begin
                unexp_hit = 1'b1;
            end
        end
    end

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        cnt_d   = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        unexp_d = unexp_q | unexp_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            unexp_q <= unexp_d;
        end
    end

    // Entry storage needs no reset: cnt gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tgt_q[wptr_q] <= sel;
            id_q[wptr_q]  <= mgr_aid_i;
        end
    end

    assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_user_obi_demux.sv
// Directed bench for user_obi_demux: a response scoreboard plus direct checks of the
// request path, ordering, back-pressure, unexpected responses and mid-operation reset.
module tb_user_obi_demux;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mgr_req_i, mgr_gnt_o, mgr_we_i;
    logic [31:0] mgr_addr_i, mgr_wdata_i;
    logic [3:0]  mgr_be_i;
    logic        mgr_aid_i;
    logic        mgr_rvalid_o, mgr_err_o, mgr_rid_o;
    logic [31:0] mgr_rdata_o;
    logic [1:0]  sbr_req_o, sbr_gnt_i, sbr_rvalid_i, sbr_err_i, sbr_rid_i;
    logic [31:0] sbr_addr_o, sbr_wdata_o;
    logic        sbr_we_o, sbr_aid_o;
    logic [3:0]  sbr_be_o;
    logic [63:0] sbr_rdata_i;
    logic        unexp_rsp_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        rid;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    user_obi_demux dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mgr_req_i    (mgr_req_i),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_addr_i   (mgr_addr_i),
        .mgr_we_i     (mgr_we_i),
        .mgr_be_i     (mgr_be_i),
        .mgr_wdata_i  (mgr_wdata_i),
        .mgr_aid_i    (mgr_aid_i),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_rdata_o  (mgr_rdata_o),
        .mgr_err_o    (mgr_err_o),
        .mgr_rid_o    (mgr_rid_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_gnt_i    (sbr_gnt_i),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_aid_o    (sbr_aid_o),
        .sbr_rvalid_i (sbr_rvalid_i),
        .sbr_rdata_i  (sbr_rdata_i),
        .sbr_err_i    (sbr_err_i),
        .sbr_rid_i    (sbr_rid_i),
        .unexp_rsp_o  (unexp_rsp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop/compare one expected response whenever the manager sees rvalid.
    task automatic sb_check();
        rsp_t e;
        if (mgr_rvalid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rsp_without_expect", 32'(mgr_rdata_o), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", mgr_rdata_o, e.rdata);
                chk("rsp_err", 32'(mgr_err_o), 32'(e.err));
                chk("rsp_rid", 32'(mgr_rid_o), 32'(e.rid));
            end
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at the negedge.
    task automatic step();
        @(negedge clk_i);
        sb_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic aid);
        mgr_req_i   = 1'b1;
        mgr_addr_i  = addr;
        mgr_we_i    = we;
        mgr_aid_i   = aid;
        mgr_wdata_i = addr ^ 32'h5A5A_5A5A;
    endtask

    task automatic drive_rsp(input int idx, input logic [31:0] data, input logic rid);
        sbr_rvalid_i = 2'b00;
        sbr_rvalid_i[idx] = 1'b1;
        sbr_rdata_i[idx*32 +: 32] = data;
        sbr_rid_i[idx] = rid;
        sbr_err_i = 2'b00;
    endtask

    initial begin
        rst_ni = 1'b0;
        mgr_req_i = 1'b0; mgr_addr_i = '0; mgr_we_i = 1'b0; mgr_be_i = 4'hF;
        mgr_wdata_i = '0; mgr_aid_i = 1'b0;
        sbr_gnt_i = 2'b00; sbr_rvalid_i = 2'b00; sbr_rdata_i = '0;
        sbr_err_i = 2'b00; sbr_rid_i = 2'b00;
        #12;
        chk("rst_rvalid", 32'(mgr_rvalid_o), 32'd0);
        chk("rst_rdata", mgr_rdata_o, 32'd0);
        chk("rst_err", 32'(mgr_err_o), 32'd0);
        chk("rst_rid", 32'(mgr_rid_o), 32'd0);
        chk("rst_unexp", 32'(unexp_rsp_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        step();

        // Single read to subordinate 0, response next cycle.
        sbr_gnt_i = 2'b01;
        drive_req(32'h2000_0004, 1'b0, 1'b1);
        #1;
        chk("rd_sbr_req", 32'(sbr_req_o), 32'b01);
        chk("rd_gnt", 32'(mgr_gnt_o), 32'd1);
        chk("rd_addr_bcast", sbr_addr_o, 32'h2000_0004);
        sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0, rid: 1'b1});
        step();
        mgr_req_i = 1'b0;
        drive_rsp(0, 32'h1234_5678, 1'b1);
        #1;
        chk("rd_rvalid", 32'(mgr_rvalid_o), 32'd1);
        step();
        sbr_rvalid_i = 2'b00;

        // Unmapped write goes to the error subordinate.
        sbr_gnt_i = 2'b00;
        drive_req(32'h3000_0000, 1'b1, 1'b1);
        #1;
        chk("err_gnt", 32'(mgr_gnt_o), 32'd1);
        chk("err_no_sbr_req", 32'(sbr_req_o), 32'b00);
        chk("err_not_same_cycle", 32'(mgr_rvalid_o), 32'd0);
        sb_q.push_back('{rdata: 32'hBADC_AB1E, err: 1'b1, rid: 1'b1});
        step();
        mgr_req_i = 1'b0;
        #1;
        chk("err_rvalid", 32'(mgr_rvalid_o), 32'd1);
        step();

        // Back-to-back error accesses: one response per cycle.
        for (int i = 0; i < 3; i++) begin
            drive_req(32'hF000_0000 + 32'(i * 4), 1'b0, 1'(i));
            sb_q.push_back('{rdata: 32'hBADC_AB1E, err: 1'b1, rid: 1'(i)});
            #1;
            if (i > 0) chk("b2b_err_rvalid", 32'(mgr_rvalid_o), 32'd1);
            step();
        end
        mgr_req_i = 1'b0;
        step();
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);

        // Fill the tracker with withheld sbr0 reads, then relieve one slot.
        sbr_gnt_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h2000_0000 + 32'(i * 4), 1'b0, 1'(i));
            #1;
            chk("fill_gnt", 32'(mgr_gnt_o), 32'd1);
            sb_q.push_back('{rdata: 32'hA000_0000 + 32'(i), err: 1'b0, rid: 1'(i)});
            step();
        end
        drive_req(32'h2000_0010, 1'b0, 1'b0);
        #1;
        chk("full_gnt", 32'(mgr_gnt_o), 32'd0);
        chk("full_sbr_req", 32'(sbr_req_o), 32'b00);
        step();
        drive_rsp(0, 32'hA000_0000, 1'b0);
        #1;
        chk("full_pop_gnt", 32'(mgr_gnt_o), 32'd0);
        step();
        sbr_rvalid_i = 2'b00;
        #1;
        chk("regain_gnt", 32'(mgr_gnt_o), 32'd1);
        chk("regain_sbr_req", 32'(sbr_req_o), 32'b01);
        sb_q.push_back('{rdata: 32'hA000_0004, err: 1'b0, rid: 1'b0});
        step();
        mgr_req_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            drive_rsp(0, 32'hA000_0000 + 32'(i), 1'(i));
            step();
        end
        sbr_rvalid_i = 2'b00;
        chk("fill_drained", 32'(sb_q.size()), 32'd0);

        // Slow sbr0 read followed by an unmapped read: error must wait its turn.
        drive_req(32'h2000_0100, 1'b0, 1'b1);
        sb_q.push_back('{rdata: 32'hC0FF_EE00, err: 1'b0, rid: 1'b1});
        step();
        drive_req(32'h4000_0000, 1'b0, 1'b0);
        #1;
        chk("order_err_gnt", 32'(mgr_gnt_o), 32'd1);
        sb_q.push_back('{rdata: 32'hBADC_AB1E, err: 1'b1, rid: 1'b0});
        step();
        mgr_req_i = 1'b0;
        #1;
        chk("order_err_held", 32'(mgr_rvalid_o), 32'd0);
        step();
        chk("order_err_held2", 32'(mgr_rvalid_o), 32'd0);
        drive_rsp(0, 32'hC0FF_EE00, 1'b1);
        step();
        sbr_rvalid_i = 2'b00;
        #1;
        chk("order_err_after", 32'(mgr_err_o), 32'd1);
        step();
        chk("order_drained", 32'(sb_q.size()), 32'd0);

        // Response from sbr1 while only sbr0 is outstanding.
        drive_req(32'h2000_0200, 1'b0, 1'b0);
        sb_q.push_back('{rdata: 32'h5555_AAAA, err: 1'b0, rid: 1'b0});
        step();
        mgr_req_i = 1'b0;
        drive_rsp(1, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("unexp_not_fwd", 32'(mgr_rvalid_o), 32'd0);
        chk("unexp_not_yet", 32'(unexp_rsp_o), 32'd0);
        step();
        sbr_rvalid_i = 2'b00;
        #1;
        chk("unexp_set", 32'(unexp_rsp_o), 32'd1);
        drive_rsp(0, 32'h5555_AAAA, 1'b0);
        step();
        sbr_rvalid_i = 2'b00;
        step();
        chk("unexp_sticky", 32'(unexp_rsp_o), 32'd1);

        // Reset with three outstanding sbr0 reads; entries are dropped.
        for (int i = 0; i < 3; i++) begin
            drive_req(32'h2000_0300 + 32'(i * 4), 1'b0, 1'b0);
            step();
        end
        mgr_req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(mgr_rvalid_o), 32'd0);
        chk("mid_rst_unexp", 32'(unexp_rsp_o), 32'd0);
        drive_rsp(0, 32'h0BAD_0BAD, 1'b0);
        #1;
        chk("mid_rst_no_fwd", 32'(mgr_rvalid_o), 32'd0);
        sbr_rvalid_i = 2'b00;
        step();
        rst_ni = 1'b1;
        drive_rsp(0, 32'h0BAD_0BAD, 1'b0);
        #1;
        chk("late_rsp_no_fwd", 32'(mgr_rvalid_o), 32'd0);
        step();
        sbr_rvalid_i = 2'b00;
        #1;
        chk("late_rsp_unexp", 32'(unexp_rsp_o), 32'd1);

        // Traffic after reset decodes to subordinate 1.
        sbr_gnt_i = 2'b10;
        drive_req(32'h2000_1008, 1'b0, 1'b1);
        #1;
        chk("post_rst_sbr_req", 32'(sbr_req_o), 32'b10);
        chk("post_rst_gnt", 32'(mgr_gnt_o), 32'd1);
        sb_q.push_back('{rdata: 32'h7777_8888, err: 1'b0, rid: 1'b1});
        step();
        mgr_req_i = 1'b0;
        drive_rsp(1, 32'h7777_8888, 1'b1);
        step();
        sbr_rvalid_i = 2'b00;
        step();
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
